// File: rtl/pwm_decoder.sv
// PWM duty-cycle decoder: measures high time and period of pwm_in in clk_1MHz cycles.
// Optional glitch filter on the synchronized input enabled by PWM_DECODER_GLITCH_FILTER_EN.
module pwm_decoder (
  input  logic        clk_1MHz,
  input  logic        reset,
  input  logic        pwm_in,
  output logic [3:0]  pulse_width,
  output logic [11:0] high_time,
  output logic [11:0] period,
  output logic        valid,
  output logic        timeout
);

  localparam logic [11:0] CntMax = 12'hFFF;

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e      state_q, state_d;
  logic        s1_q, s2_q, prev_q;
  logic        pwm_s, rise;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] pcnt_q, pcnt_d;
  logic [11:0] high_time_q, high_time_d;
  logic [11:0] period_q, period_d;
  logic [3:0]  pw_q, pw_d;
  logic        valid_q, valid_d;
  logic        timeout_q, timeout_d;
  logic [12:0] pw_sum, pw_div;
  logic [3:0]  pw_code;

`ifdef PWM_DECODER_GLITCH_FILTER_EN
  logic h1_q, h2_q, filt_q;

  // Output follows the sampled level only once three consecutive samples agree.
  assign pwm_s = ((s2_q == h1_q) && (h1_q == h2_q)) ? s2_q : filt_q;

  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      h1_q   <= 1'b0;
      h2_q   <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      h1_q   <= s2_q;
      h2_q   <= h1_q;
      filt_q <= pwm_s;
    end
  end
`else
  assign pwm_s = s2_q;
`endif

  assign rise = pwm_s & ~prev_q;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == CntMax) ? v : v + 12'd1;
  endfunction

  // Full-width rounding before saturation so large counts cannot alias to small codes.
  always_comb begin
    pw_sum  = {1'b0, hcnt_q} + 13'd50;
    pw_div  = pw_sum / 13'd100;
    pw_code = (pw_div > 13'd15) ? 4'd15 : pw_div[3:0];
  end

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    high_time_d = high_time_q;
    period_d    = period_q;
    pw_d        = pw_q;
    valid_d     = 1'b0;
    timeout_d   = timeout_q;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d = StHigh;
          hcnt_d  = 12'd1;
          pcnt_d  = 12'd1;
        end else if (pcnt_q == CntMax) begin
          timeout_d = 1'b1;
          pw_d      = pwm_s ? 4'd15 : 4'd0;
          pcnt_d    = 12'd0;
        end else begin
          pcnt_d = sat_inc(pcnt_q);
        end
      end
      StHigh: begin
        if (pcnt_q == CntMax) begin
          timeout_d = 1'b1;
          pw_d      = pwm_s ? 4'd15 : 4'd0;
          hcnt_d    = 12'd0;
          pcnt_d    = 12'd0;
          state_d   = StIdle;
        end else if (pwm_s) begin
          hcnt_d = sat_inc(hcnt_q);
          pcnt_d = sat_inc(pcnt_q);
        end else begin
          pcnt_d  = sat_inc(pcnt_q);
          state_d = StLow;
        end
      end
      StLow: begin
        // An edge wins over saturation arriving in the same cycle.
        if (rise) begin
          high_time_d = hcnt_q;
          period_d    = pcnt_q;
          pw_d        = pw_code;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          hcnt_d      = 12'd1;
          pcnt_d      = 12'd1;
          state_d     = StHigh;
        end else if (pcnt_q == CntMax) begin
          timeout_d = 1'b1;
          pw_d      = pwm_s ? 4'd15 : 4'd0;
          hcnt_d    = 12'd0;
          pcnt_d    = 12'd0;
          state_d   = StIdle;
        end else begin
          pcnt_d = sat_inc(pcnt_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (reset) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      prev_q      <= 1'b0;
      state_q     <= StIdle;
      hcnt_q      <= 12'd0;
      pcnt_q      <= 12'd0;
      high_time_q <= 12'd0;
      period_q    <= 12'd0;
      pw_q        <= 4'd0;
      valid_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      s1_q        <= pwm_in;
      s2_q        <= s1_q;
      prev_q      <= pwm_s;
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      pcnt_q      <= pcnt_d;
      high_time_q <= high_time_d;
      period_q    <= period_d;
      pw_q        <= pw_d;
      valid_q     <= valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign pulse_width = pw_q;
  assign high_time   = high_time_q;
  assign period      = period_q;
  assign valid       = valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed self-checking bench for pwm_decoder.
`timescale 1ns/1ps
module tb_pwm_decoder;

  logic        clk_1MHz = 1'b0;
  logic        reset;
  logic        pwm_in;
  logic [3:0]  pulse_width;
  logic [11:0] high_time;
  logic [11:0] period;
  logic        valid;
  logic        timeout;

  int          tests = 0;
  int          fails = 0;
  int          vcnt = 0;
  int          v0;
  logic [11:0] v_ht, v_per;
  logic [3:0]  v_pw;
  logic        v_to;

  pwm_decoder dut (
    .clk_1MHz    (clk_1MHz),
    .reset       (reset),
    .pwm_in      (pwm_in),
    .pulse_width (pulse_width),
    .high_time   (high_time),
    .period      (period),
    .valid       (valid),
    .timeout     (timeout)
  );

  always #5 clk_1MHz = ~clk_1MHz;

  // Capture every valid strobe and the outputs presented with it.
  always @(posedge clk_1MHz) begin
    #1;
    if (valid === 1'b1) begin
      vcnt = vcnt + 1;
      v_ht  = high_time;
      v_per = period;
      v_pw  = pulse_width;
      v_to  = timeout;
    end
  end

  task automatic drive(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge clk_1MHz);
  endtask

  task automatic pwm_period(input int h, input int p);
    drive(1'b1, h);
    drive(1'b0, p - h);
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk_1MHz);
    tests++; if (pulse_width !== 4'd0) begin fails++; $display("FAIL reset_pw got %0d want 0", pulse_width); end
    tests++; if (high_time !== 12'd0) begin fails++; $display("FAIL reset_ht got %0d want 0", high_time); end
    tests++; if (period !== 12'd0) begin fails++; $display("FAIL reset_per got %0d want 0", period); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", valid); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_to got %b want 0", timeout); end
    reset = 1'b0;
    drive(1'b0, 10);
  endtask

  task automatic test_basic;
    v0 = vcnt;
    pwm_period(500, 2000);
    pwm_period(500, 2000);
    tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL basic_cnt1 got %0d want %0d", vcnt - v0, 1); end
    tests++; if (v_ht !== 12'd500) begin fails++; $display("FAIL basic_ht got %0d want 500", v_ht); end
    tests++; if (v_per !== 12'd2000) begin fails++; $display("FAIL basic_per got %0d want 2000", v_per); end
    tests++; if (v_pw !== 4'd5) begin fails++; $display("FAIL basic_pw got %0d want 5", v_pw); end
    pwm_period(500, 2000);
    tests++; if (vcnt !== v0 + 2) begin fails++; $display("FAIL basic_cnt2 got %0d want %0d", vcnt - v0, 2); end
    tests++; if (high_time !== 12'd500) begin fails++; $display("FAIL basic_ht2 got %0d want 500", high_time); end
    tests++; if (period !== 12'd2000) begin fails++; $display("FAIL basic_per2 got %0d want 2000", period); end
    tests++; if (pulse_width !== 4'd5) begin fails++; $display("FAIL basic_pw2 got %0d want 5", pulse_width); end
  endtask

  task automatic test_sweep;
    int highs [19] = '{100, 200, 300, 400, 500, 600, 700, 800, 900, 1000,
                       1100, 1200, 1300, 1400, 1500, 149, 150, 1999, 100};
    int exp_pw [19] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 1, 2, 15, 1};
    for (int i = 0; i < 19; i++) begin
      v0 = vcnt;
      pwm_period(highs[i], 2000);
      if (i > 0) begin
        tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL sweep_cnt[%0d] got %0d want 1", i, vcnt - v0); end
        tests++; if (v_pw !== exp_pw[i-1]) begin fails++; $display("FAIL sweep_pw[%0d] got %0d want %0d", i, v_pw, exp_pw[i-1]); end
        tests++; if (v_ht !== highs[i-1]) begin fails++; $display("FAIL sweep_ht[%0d] got %0d want %0d", i, v_ht, highs[i-1]); end
        tests++; if (v_per !== 12'd2000) begin fails++; $display("FAIL sweep_per[%0d] got %0d want 2000", i, v_per); end
      end
    end
  endtask

  task automatic test_timeout_low;
    v0 = vcnt;
    drive(1'b0, 5000);
    tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL tol_to got %b want 1", timeout); end
    tests++; if (pulse_width !== 4'd0) begin fails++; $display("FAIL tol_pw got %0d want 0", pulse_width); end
    tests++; if (period !== 12'd2000) begin fails++; $display("FAIL tol_per got %0d want 2000", period); end
    tests++; if (high_time !== 12'd1999) begin fails++; $display("FAIL tol_ht got %0d want 1999", high_time); end
    tests++; if (vcnt !== v0) begin fails++; $display("FAIL tol_cnt got %0d want 0", vcnt - v0); end
  endtask

  task automatic test_resume;
    v0 = vcnt;
    pwm_period(300, 2000);
    tests++; if (vcnt !== v0) begin fails++; $display("FAIL res_cnt1 got %0d want 0", vcnt - v0); end
    tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL res_to1 got %b want 1", timeout); end
    pwm_period(300, 2000);
    tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL res_cnt2 got %0d want 1", vcnt - v0); end
    tests++; if (v_pw !== 4'd3) begin fails++; $display("FAIL res_pw got %0d want 3", v_pw); end
    tests++; if (v_to !== 1'b0) begin fails++; $display("FAIL res_to_at_valid got %b want 0", v_to); end
    tests++; if (v_ht !== 12'd300) begin fails++; $display("FAIL res_ht got %0d want 300", v_ht); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL res_to2 got %b want 0", timeout); end
  endtask

  task automatic test_timeout_high;
    v0 = vcnt;
    drive(1'b1, 5000);
    tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL toh_cnt got %0d want 1", vcnt - v0); end
    tests++; if (timeout !== 1'b1) begin fails++; $display("FAIL toh_to got %b want 1", timeout); end
    tests++; if (pulse_width !== 4'd15) begin fails++; $display("FAIL toh_pw got %0d want 15", pulse_width); end
    tests++; if (high_time !== 12'd300) begin fails++; $display("FAIL toh_ht got %0d want 300", high_time); end
    tests++; if (period !== 12'd2000) begin fails++; $display("FAIL toh_per got %0d want 2000", period); end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 100);
    pwm_period(500, 2000);
    pwm_period(500, 2000);
    drive(1'b1, 500);
    drive(1'b0, 300);
    reset = 1'b1;
    drive(1'b0, 2);
    drive(1'b1, 3);
    tests++; if (pulse_width !== 4'd0) begin fails++; $display("FAIL rmid_pw got %0d want 0", pulse_width); end
    tests++; if (high_time !== 12'd0) begin fails++; $display("FAIL rmid_ht got %0d want 0", high_time); end
    tests++; if (period !== 12'd0) begin fails++; $display("FAIL rmid_per got %0d want 0", period); end
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got %b want 0", valid); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL rmid_to got %b want 0", timeout); end
    drive(1'b0, 3);
    reset = 1'b0;
    drive(1'b0, 1200);
    v0 = vcnt;
    pwm_period(500, 2000);
    tests++; if (vcnt !== v0) begin fails++; $display("FAIL rmid_cnt1 got %0d want 0", vcnt - v0); end
    tests++; if (period !== 12'd0) begin fails++; $display("FAIL rmid_per1 got %0d want 0", period); end
    pwm_period(500, 2000);
    tests++; if (vcnt !== v0 + 1) begin fails++; $display("FAIL rmid_cnt2 got %0d want 1", vcnt - v0); end
    tests++; if (v_ht !== 12'd500) begin fails++; $display("FAIL rmid_ht2 got %0d want 500", v_ht); end
    tests++; if (v_per !== 12'd2000) begin fails++; $display("FAIL rmid_per2 got %0d want 2000", v_per); end
    tests++; if (v_pw !== 4'd5) begin fails++; $display("FAIL rmid_pw2 got %0d want 5", v_pw); end
  endtask

  task automatic test_glitch;
    int          exp_cnt;
    logic [11:0] exp_ht, exp_per;
    logic [3:0]  exp_pw;
`ifdef PWM_DECODER_GLITCH_FILTER_EN
    exp_cnt = 2; exp_ht = 12'd500; exp_per = 12'd2000; exp_pw = 4'd5;
`else
    exp_cnt = 3; exp_ht = 12'd1; exp_per = 12'd800; exp_pw = 4'd0;
`endif
    v0 = vcnt;
    drive(1'b1, 500);
    drive(1'b0, 700);
    drive(1'b1, 1);
    drive(1'b0, 799);
    drive(1'b1, 10);
    tests++; if (vcnt !== v0 + exp_cnt) begin fails++; $display("FAIL glitch_cnt got %0d want %0d", vcnt - v0, exp_cnt); end
    tests++; if (v_ht !== exp_ht) begin fails++; $display("FAIL glitch_ht got %0d want %0d", v_ht, exp_ht); end
    tests++; if (v_per !== exp_per) begin fails++; $display("FAIL glitch_per got %0d want %0d", v_per, exp_per); end
    tests++; if (v_pw !== exp_pw) begin fails++; $display("FAIL glitch_pw got %0d want %0d", v_pw, exp_pw); end
  endtask

  task automatic test_back_to_back;
    drive(1'b0, 100);
    v0 = vcnt;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1);
      drive(1'b0, 1);
    end
    drive(1'b1, 5);
    tests++; if (vcnt !== v0 + 7) begin fails++; $display("FAIL b2b_cnt got %0d want 7", vcnt - v0); end
    tests++; if (v_per !== 12'd2) begin fails++; $display("FAIL b2b_per got %0d want 2", v_per); end
    tests++; if (v_ht !== 12'd1) begin fails++; $display("FAIL b2b_ht got %0d want 1", v_ht); end
    tests++; if (v_pw !== 4'd0) begin fails++; $display("FAIL b2b_pw got %0d want 0", v_pw); end
  endtask

  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    test_reset;
    test_basic;
    test_sweep;
    test_timeout_low;
    test_resume;
    test_timeout_high;
    test_reset_mid;
    test_glitch;
`ifndef PWM_DECODER_GLITCH_FILTER_EN
    test_back_to_back;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm_decoder.md
PWM_DECODER -- requirements
Module: pwm_decoder

Interface
REQ-001 The block SHALL have the port clk_1MHz, input, 1 bit: the single 1 MHz system clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port pwm_in, input, 1 bit: asynchronous PWM waveform to measure (nominal 2000-cycle period, high time = code*100 cycles).
REQ-004 The block SHALL have the port pulse_width, output, 4 bits: decoded duty code 0..15.
REQ-005 The block SHALL have the port high_time, output, 12 bits: last measured high time in clk_1MHz cycles.
REQ-006 The block SHALL have the port period, output, 12 bits: last measured rising-edge-to-rising-edge period in clk_1MHz cycles.
REQ-007 The block SHALL have the port valid, output, 1 bit: one-cycle strobe when pulse_width, high_time and period update from a complete period.
REQ-008 The block SHALL have the port timeout, output, 1 bit: level; no rising edge seen for 4095 cycles.

Function
REQ-009 pwm_in SHALL pass through a 2-flop synchronizer to give pwm_s; a rising edge is pwm_s=1 while its previous-cycle value is 0.
REQ-010 The FSM SHALL have states IDLE, HIGH and LOW.
REQ-011 IDLE: wait for a rising edge, then go to HIGH with hcnt=1 and pcnt=1; no valid is issued for this first edge.
REQ-012 HIGH: increment hcnt and pcnt each cycle while pwm_s=1; on pwm_s=0 go to LOW and increment pcnt.
REQ-013 LOW: increment pcnt each cycle; on a rising edge latch high_time=hcnt and period=pcnt, then restart with hcnt=1, pcnt=1 and go to HIGH.
REQ-014 valid SHALL pulse high on the cycle after the latching edge cycle, coincident with the new output values.
REQ-015 pulse_width SHALL equal floor((hcnt+50)/100) saturated to 15; the arithmetic SHALL be integer-only with no truncation before saturation.
REQ-016 hcnt and pcnt SHALL saturate at 4095 and SHALL never wrap.
REQ-017 If pcnt reaches 4095 in HIGH or LOW, the block SHALL:
  - set timeout=1;
  - set pulse_width to 15 if pwm_s=1, else 0;
  - leave high_time and period unchanged;
  - issue no valid;
  - go to IDLE.
REQ-018 timeout SHALL also assert from IDLE after 4095 cycles with no rising edge, with the same pulse_width rule.
REQ-019 timeout SHALL clear on the same cycle that valid next asserts.
REQ-020 A rising edge and saturation in the same cycle SHALL be treated as an edge: latch, valid, no timeout.
REQ-021 An edge on the cycle following a latch SHALL be measured normally; a period of 2 cycles is the minimum legal measurement.

Reset
REQ-022 Reset SHALL set all outputs to 0, the FSM to IDLE, counters to 0 and synchronizer flops to 0.
REQ-023 Reset asserted mid-measurement SHALL discard the partial period; the first post-reset rising edge only starts a measurement.
REQ-024 Outputs SHALL hold their reset values while reset=1, regardless of pwm_in.

Configuration
REQ-025 Macro PWM_DECODER_GLITCH_FILTER_EN defined: pwm_s SHALL change only after 3 consecutive identical synchronized samples, adding 2 cycles of latency to both edges, so high_time and period are unchanged for clean inputs.
REQ-026 Macro PWM_DECODER_GLITCH_FILTER_EN defined: pulses of 1-2 cycles on pwm_in SHALL be rejected.
REQ-027 Macro PWM_DECODER_GLITCH_FILTER_EN undefined: no filter; every synchronized transition SHALL count.

Verification
REQ-028 Scenario: after reset, 3 periods of 500 high / 1500 low -> valid pulses after the 2nd and 3rd rising edges; each shows high_time=500, period=2000, pulse_width=5.
REQ-029 Scenario: sweep codes 1..15 (code*100 high, 2000 period) -> pulse_width equals the code; high_time=149 gives 1, 150 gives 2; high_time=1999 gives 15 (saturated).
REQ-030 Scenario: pwm_in held 0 for 5000 cycles after a valid period -> timeout=1, pulse_width=0, period retains 2000, no valid; held 1 instead -> pulse_width=15.
REQ-031 Scenario: timeout active, then resume 300/2000 waveform -> first edge gives no valid; second edge gives valid with pulse_width=3 and timeout=0 in the same cycle.
REQ-032 Scenario: reset pulsed at cycle 800 of a period -> all outputs 0; next valid arrives only after two further rising edges.
REQ-033 Scenario: 1-cycle glitch injected mid-LOW -> with PWM_DECODER_GLITCH_FILTER_EN, period=2000 unaffected; without it, a short period and high_time=1 are reported.
